// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the peripheral bus master
//
// Purpose: state encoding, data/address widths and the default memory depth
// used by apb_bus_master and anything that talks to it.
// Ports: none (package).

package bus_pkg;

  localparam int ADDR_W            = 32;
  localparam int DATA_W            = 32;
  localparam int MEM_WORDS_DEFAULT = 101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/apb_bus_master.sv
// rtl/apb_bus_master.sv - single-transfer bus master for the word-addressed data memory
//
// Purpose: accepts one load/store from the core at a time, runs it through
// SETUP/ACCESS (plus CAPTURE for loads) bus phases, and answers the core with
// a one-cycle response pulse. Out-of-range addresses are answered with an
// error and never reach the bus.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   core request handshake (ready only while idle)
//   req_write         1 = store, 0 = load
//   req_addr          word address, forwarded unchanged to PADDR
//   req_wdata         store data
//   resp_valid        one-cycle completion pulse
//   resp_err          address was out of range, no bus transfer happened
//   resp_rdata        load data, held until the next load capture
//   PADDR, we,        bus address, write strobe, access-phase strobe
//   PENABLE
//   BUS               shared data bus; driven here only while we = 1

module apb_bus_master
  import bus_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] PADDR,
  output logic              we,
  output logic              PENABLE,
  inout  wire  [DATA_W-1:0] BUS
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS);

  state_t            state;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  // we is only ever high in SETUP/ACCESS of a store, so the memory's read
  // driver and this driver can never overlap.
  assign BUS = we ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      PADDR      <= '0;
      we         <= 1'b0;
      PENABLE    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_addr >= ADDR_LIMIT) begin
              // Range error: answer straight away, leave the bus untouched.
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state <= ST_SETUP;
              PADDR <= req_addr;
              we    <= req_write;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          // Memory commits / loads its read register on the edge leaving here.
          PENABLE <= 1'b0;
          we      <= 1'b0;
          if (write_q) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // BUS now carries the memory's registered read data.
          resp_rdata <= BUS;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          we         <= 1'b0;
          PENABLE    <= 1'b0;
        end
      endcase
    end
  end

endmodule
